seq_detect_ctrl: RTL and testbench
==================================

# seq_detect_ctrl

Run controller and pattern scheduler for the programmable serial sequence detector datapath. Holds a bank of `NUM_PAT` programmable patterns and shifts a gated serial bit stream into one shared `SEQ_W`-bit history window. It sequences the window through an explicit fill phase, so no match is reported against post-reset zeros, then compares the window against every enabled slot. It reports prioritised hits and a saturating hit count to the surrounding control logic.

## Interface
- `SEQ_W`, 5, pattern/window width in bits; legal range is 2 or more.
- `NUM_PAT`, 4, number of pattern slots; legal range is 2 or more.
- `CNT_W`, 8, width of the saturating hit counter.
- `IDX_W`, `$clog2(NUM_PAT)`, derived, slot index width.

Ports:
- `clk`  in  1  the only clock; all state changes on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  slot write request.
- `cfg_ready`  out  1  slot write accepted; high only in IDLE.
- `cfg_idx`  in  IDX_W  slot to write.
- `cfg_pat`  in  SEQ_W  pattern; bit 0 is the most recent bit.
- `cfg_en`  in  1  slot enable written with the pattern.
- `start`  in  1  begin a detection run.
- `stop`  in  1  end the run and return to IDLE.
- `din_valid`  in  1  `din` carries a stream bit this cycle.
- `din`  in  1  serial stream bit.
- `busy`  out  1  state is not IDLE.
- `hit_valid`  out  1  registered hit pulse.
- `hit_mask`  out  NUM_PAT  all enabled slots matching this bit.
- `hit_idx`  out  IDX_W  lowest-index matching slot.
- `hit_cnt`  out  CNT_W  number of hit events, saturating.

## Operation
- States: IDLE, FILL, RUN.
- IDLE:
  - A write completes when `cfg_valid && cfg_ready`; it stores `cfg_pat` and `cfg_en` into slot `cfg_idx`.
  - `cfg_idx >= NUM_PAT` is ignored but still handshaken.
  - `start` moves to FILL and clears the window, the fill counter and `hit_cnt`.
  - `din_valid` is ignored.
- FILL:
  - Each accepted bit gives window ← {window[SEQ_W-2:0], din} and increments the fill counter.
  - The bit that brings the count to `SEQ_W` is compared and moves the state to RUN.
- RUN:
  - Every accepted bit shifts the window and is compared.
  - Overlapping matches are all reported.
- Compare: the post-shift window is compared against each slot with `en` set.
  - `hit_mask[i]` = en[i] && (pat[i] == window_next).
  - Any mask bit set makes it a hit event.
  - `hit_idx` is the lowest set bit of the mask, or 0 if none.
- `hit_cnt` increments by 1 per hit event, not per slot, and saturates at 2^CNT_W−1.
- `stop` in FILL or RUN moves to IDLE. The window is kept and `hit_cnt` is kept until the next `start`.
- Simultaneous events:
  - `stop` with `din_valid`: stop wins and the bit is discarded.
  - `start` outside IDLE is ignored.
  - `start` with a slot write in IDLE: both take effect, and the new slot contents are used.
  - `start` with `stop` in IDLE: start wins.
- Slots cannot change during a run because `cfg_ready` is 0 outside IDLE.
- Reset, including mid-run:
  - state goes to IDLE;
  - window, fill counter, all slot patterns and enables are cleared to 0;
  - `hit_valid`, `hit_mask`, `hit_idx` and `hit_cnt` are cleared to 0;
  - `busy` is 0 and `cfg_ready` is 1.

## Timing
- `cfg_ready` and `busy` are combinational from the state register.
- A slot write is visible to comparisons from the next cycle.
- Hit latency is 1 cycle:
  - bit accepted in cycle t gives `hit_valid`, `hit_mask` and `hit_idx` in cycle t+1;
  - they stay valid for exactly one cycle;
  - `hit_mask` and `hit_idx` are 0 when `hit_valid` is 0.
- `hit_cnt` updates in the same cycle as `hit_valid`.
- A compare in the cycle a stop takes effect cannot occur, because the bit is discarded.
- Minimum first hit after `start` in cycle s: `start` at s, bits at s+1 through s+SEQ_W, `hit_valid` at s+SEQ_W+1.
- `din_valid` gaps stall FILL and RUN; there is no timeout.

## Structure
- Shared package `seq_detect_pkg` holds:
  - the state enum `seq_ctrl_state_e` (IDLE, FILL, RUN);
  - the default widths `SEQ_W_DEF` and `NUM_PAT_DEF`.
- One sub-module `seq_pattern_bank`:
  - slot registers, write port and enables;
  - parallel comparators producing `hit_mask`;
  - a lowest-index priority encoder.
- The top level keeps the FSM, window, fill counter, output registers and `hit_cnt`.

## Test plan
- Reset then idle:
  - resetn low mid-run with bits streaming → all outputs 0, `cfg_ready` 1;
  - after release, `start` with slot 0 = 00000 enabled and five 0 bits → exactly one hit, never an earlier one.
- Basic hit:
  - slot 1 = 10110 enabled, start, stream 1,0,1,1,0 → `hit_valid` one cycle after the 5th bit, `hit_mask` = 0010, `hit_idx` = 1, `hit_cnt` = 1.
- Priority and overlap:
  - slots 0 and 2 both = 10101 enabled, stream 1,0,1,0,1,0,1 → two hits (after bits 5 and 7), each with mask 0101 and idx 0, `hit_cnt` = 2.
- Gating and stop:
  - `din_valid` gaps of 3 cycles inside the pattern → the hit is still reported;
  - `stop` asserted together with the final pattern bit → no hit, state IDLE, `hit_cnt` unchanged.
- Config handshake:
  - `cfg_valid` during RUN → `cfg_ready` 0 and slot unchanged;
  - write with start in the same IDLE cycle → the new pattern is matched;
  - disabled slot with a matching pattern → never hits.
- Saturation:
  - CNT_W = 2, slot = 11111, stream ten 1s → six hits reported, `hit_cnt` stops at 3.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and default widths for the serial sequence detector.
package seq_detect_pkg;

  localparam int unsigned SEQ_W_DEF   = 5;
  localparam int unsigned NUM_PAT_DEF = 4;
  localparam int unsigned CNT_W_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } seq_ctrl_state_e;

endpackage

// File: rtl/seq_detect_if.sv
// Config, stream and hit-report signals of the sequence detector controller.
interface seq_detect_if
  import seq_detect_pkg::*;
#(
  parameter int unsigned SEQ_W   = SEQ_W_DEF,
  parameter int unsigned NUM_PAT = NUM_PAT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) ();
  localparam int unsigned IDX_W = $clog2(NUM_PAT);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [IDX_W-1:0]   cfg_idx;
  logic [SEQ_W-1:0]   cfg_pat;
  logic               cfg_en;
  logic               start;
  logic               stop;
  logic               din_valid;
  logic               din;
  logic               busy;
  logic               hit_valid;
  logic [NUM_PAT-1:0] hit_mask;
  logic [IDX_W-1:0]   hit_idx;
  logic [CNT_W-1:0]   hit_cnt;

  modport master (
    output cfg_valid, cfg_idx, cfg_pat, cfg_en, start, stop, din_valid, din,
    input  cfg_ready, busy, hit_valid, hit_mask, hit_idx, hit_cnt
  );

  modport slave (
    input  cfg_valid, cfg_idx, cfg_pat, cfg_en, start, stop, din_valid, din,
    output cfg_ready, busy, hit_valid, hit_mask, hit_idx, hit_cnt
  );

endinterface

// File: rtl/seq_pattern_bank.sv
// Programmable pattern slots with parallel comparators and a lowest-index
// priority encoder over the match mask.
module seq_pattern_bank
  import seq_detect_pkg::*;
#(
  parameter int unsigned SEQ_W   = SEQ_W_DEF,
  parameter int unsigned NUM_PAT = NUM_PAT_DEF
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       i_wr_en,
  input  logic [$clog2(NUM_PAT)-1:0] i_wr_idx,
  input  logic [SEQ_W-1:0]           i_wr_pat,
  input  logic                       i_wr_slot_en,
  input  logic [SEQ_W-1:0]           i_window,
  output logic [NUM_PAT-1:0]         o_hit_mask_c,
  output logic [$clog2(NUM_PAT)-1:0] o_hit_idx_c,
  output logic                       o_hit_any_c
);
  localparam int unsigned IDX_W = $clog2(NUM_PAT);

  logic [SEQ_W-1:0]   r_pat [NUM_PAT];
  logic [NUM_PAT-1:0] r_en;
  logic               w_idx_ok;

  // Out-of-range slot indices exist only when NUM_PAT is not a power of two.
  generate
    if (NUM_PAT == 2 ** IDX_W) begin : g_idx_full
      assign w_idx_ok = 1'b1;
    end else begin : g_idx_part
      assign w_idx_ok = (32'(i_wr_idx) < NUM_PAT);
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(NUM_PAT); i++) r_pat[i] <= '0;
      r_en <= '0;
    end else if (i_wr_en && w_idx_ok) begin
      r_pat[i_wr_idx] <= i_wr_pat;
      r_en[i_wr_idx]  <= i_wr_slot_en;
    end
  end

  always_comb begin
    o_hit_mask_c = '0;
    for (int i = 0; i < int'(NUM_PAT); i++)
      o_hit_mask_c[i] = r_en[i] && (r_pat[i] == i_window);
  end

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    o_hit_idx_c = '0;
    for (int i = int'(NUM_PAT) - 1; i >= 0; i--)
      if (o_hit_mask_c[i]) o_hit_idx_c = IDX_W'(i);
  end

  assign o_hit_any_c = |o_hit_mask_c;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for the serial sequence detector: fill/run sequencing of the
// history window, registered hit reporting and a saturating hit counter.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int unsigned SEQ_W   = SEQ_W_DEF,
  parameter int unsigned NUM_PAT = NUM_PAT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic     clk,
  input  logic     resetn,
  seq_detect_if.slave bus
);
  localparam int unsigned IDX_W  = $clog2(NUM_PAT);
  localparam int unsigned FILL_W = $clog2(SEQ_W + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SEQ_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  seq_ctrl_state_e    r_state;
  seq_ctrl_state_e    w_state_next;
  logic [SEQ_W-1:0]   r_window;
  logic [SEQ_W-1:0]   w_window_next;
  logic [FILL_W-1:0]  r_fill_cnt;
  logic               r_hit_valid;
  logic [NUM_PAT-1:0] r_hit_mask;
  logic [IDX_W-1:0]   r_hit_idx;
  logic [CNT_W-1:0]   r_hit_cnt;

  logic               w_idle;
  logic               w_run_start;
  logic               w_cfg_wr;
  logic               w_bit_acc;
  logic               w_cmp;
  logic [NUM_PAT-1:0] w_hit_mask;
  logic [IDX_W-1:0]   w_hit_idx;
  logic               w_hit_any;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = FILL;
      FILL:    if (bus.stop) w_state_next = IDLE;
               else if (w_cmp) w_state_next = RUN;
      RUN:     if (bus.stop) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Stop discards a same-cycle stream bit; only the SEQ_W-th fill bit compares.
  always_comb begin
    w_idle        = (r_state == IDLE);
    w_run_start   = w_idle && bus.start;
    w_cfg_wr      = w_idle && bus.cfg_valid;
    w_bit_acc     = !w_idle && bus.din_valid && !bus.stop;
    w_cmp         = w_bit_acc &&
                    ((r_state == RUN) || ((r_state == FILL) && (r_fill_cnt == FILL_LAST)));
    w_window_next = {r_window[SEQ_W-2:0], bus.din};
  end

  seq_pattern_bank #(
    .SEQ_W   (SEQ_W),
    .NUM_PAT (NUM_PAT)
  ) u_bank (
    .clk          (clk),
    .resetn       (resetn),
    .i_wr_en      (w_cfg_wr),
    .i_wr_idx     (bus.cfg_idx),
    .i_wr_pat     (bus.cfg_pat),
    .i_wr_slot_en (bus.cfg_en),
    .i_window     (w_window_next),
    .o_hit_mask_c (w_hit_mask),
    .o_hit_idx_c  (w_hit_idx),
    .o_hit_any_c  (w_hit_any)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_window    <= '0;
      r_fill_cnt  <= '0;
      r_hit_valid <= 1'b0;
      r_hit_mask  <= '0;
      r_hit_idx   <= '0;
      r_hit_cnt   <= '0;
    end else begin
      r_hit_valid <= w_cmp && w_hit_any;
      r_hit_mask  <= w_cmp ? w_hit_mask : '0;
      r_hit_idx   <= w_cmp ? w_hit_idx  : '0;
      if (w_run_start) begin
        r_window   <= '0;
        r_fill_cnt <= '0;
        r_hit_cnt  <= '0;
      end else if (w_bit_acc) begin
        r_window <= w_window_next;
        if (r_state == FILL) r_fill_cnt <= r_fill_cnt + FILL_W'(1);
        if (w_cmp && w_hit_any && (r_hit_cnt != CNT_MAX))
          r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.cfg_ready = w_idle;
  assign bus.busy      = !w_idle;
  assign bus.hit_valid = r_hit_valid;
  assign bus.hit_mask  = r_hit_mask;
  assign bus.hit_idx   = r_hit_idx;
  assign bus.hit_cnt   = r_hit_cnt;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed and randomized bench for seq_detect_ctrl, checked against a
// bit-history reference model; a second instance has a 2-bit hit counter.
module tb_seq_detect_ctrl;

  localparam int SEQ_W   = 5;
  localparam int NUM_PAT = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_W_S = 2;
  localparam int IDX_W   = 2;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic             cfg_valid, cfg_en, start, stop, din_valid, din;
  logic [IDX_W-1:0] cfg_idx;
  logic [SEQ_W-1:0] cfg_pat;

  seq_detect_if #(.SEQ_W(SEQ_W), .NUM_PAT(NUM_PAT), .CNT_W(CNT_W))   bus_a ();
  seq_detect_if #(.SEQ_W(SEQ_W), .NUM_PAT(NUM_PAT), .CNT_W(CNT_W_S)) bus_b ();

  assign bus_a.cfg_valid = cfg_valid;  assign bus_b.cfg_valid = cfg_valid;
  assign bus_a.cfg_idx   = cfg_idx;    assign bus_b.cfg_idx   = cfg_idx;
  assign bus_a.cfg_pat   = cfg_pat;    assign bus_b.cfg_pat   = cfg_pat;
  assign bus_a.cfg_en    = cfg_en;     assign bus_b.cfg_en    = cfg_en;
  assign bus_a.start     = start;      assign bus_b.start     = start;
  assign bus_a.stop      = stop;       assign bus_b.stop      = stop;
  assign bus_a.din_valid = din_valid;  assign bus_b.din_valid = din_valid;
  assign bus_a.din       = din;        assign bus_b.din       = din;

  seq_detect_ctrl #(.SEQ_W(SEQ_W), .NUM_PAT(NUM_PAT), .CNT_W(CNT_W)) u_dut_a (
    .clk (clk), .resetn (resetn), .bus (bus_a)
  );
  seq_detect_ctrl #(.SEQ_W(SEQ_W), .NUM_PAT(NUM_PAT), .CNT_W(CNT_W_S)) u_dut_b (
    .clk (clk), .resetn (resetn), .bus (bus_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_hits  = 0;

  // Reference model: slot table, run flag, count of bits seen and bit history.
  int m_pat [NUM_PAT];
  bit m_en  [NUM_PAT];
  bit m_act;
  int m_seen, m_hist, m_cnt_a, m_cnt_b;
  bit e_valid;
  int e_mask, e_idx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_PAT; i++) begin m_pat[i] = 0; m_en[i] = 0; end
    m_act = 0; m_seen = 0; m_hist = 0; m_cnt_a = 0; m_cnt_b = 0;
    e_valid = 0; e_mask = 0; e_idx = 0;
  endtask

  task automatic model_step(input bit cv, input int ci, input int cp, input bit ce,
                            input bit st, input bit sp, input bit dv, input bit d);
    e_valid = 0; e_mask = 0; e_idx = 0;
    if (!m_act) begin
      if (cv && ci < NUM_PAT) begin m_pat[ci] = cp; m_en[ci] = ce; end
      if (st) begin m_act = 1; m_seen = 0; m_hist = 0; m_cnt_a = 0; m_cnt_b = 0; end
    end else if (sp) begin
      m_act = 0;
    end else if (dv) begin
      m_hist = (m_hist * 2 + int'(d)) % (1 << SEQ_W);
      m_seen++;
      if (m_seen >= SEQ_W) begin
        for (int i = NUM_PAT - 1; i >= 0; i--)
          if (m_en[i] && m_pat[i] == m_hist) begin e_mask |= (1 << i); e_idx = i; end
        if (e_mask != 0) begin
          e_valid = 1;
          if (m_cnt_a < (1 << CNT_W) - 1)   m_cnt_a++;
          if (m_cnt_b < (1 << CNT_W_S) - 1) m_cnt_b++;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("busy",        32'(bus_a.busy),      32'(m_act));
    chk("cfg_ready",   32'(bus_a.cfg_ready), 32'(!m_act));
    chk("hit_valid",   32'(bus_a.hit_valid), 32'(e_valid));
    chk("hit_mask",    32'(bus_a.hit_mask),  32'(e_mask));
    chk("hit_idx",     32'(bus_a.hit_idx),   32'(e_idx));
    chk("hit_cnt",     32'(bus_a.hit_cnt),   32'(m_cnt_a));
    chk("b_busy",      32'(bus_b.busy),      32'(m_act));
    chk("b_cfg_ready", 32'(bus_b.cfg_ready), 32'(!m_act));
    chk("b_hit_valid", 32'(bus_b.hit_valid), 32'(e_valid));
    chk("b_hit_mask",  32'(bus_b.hit_mask),  32'(e_mask));
    chk("b_hit_idx",   32'(bus_b.hit_idx),   32'(e_idx));
    chk("b_hit_cnt",   32'(bus_b.hit_cnt),   32'(m_cnt_b));
  endtask

  task automatic cyc(input bit cv, input int ci, input int cp, input bit ce,
                     input bit st, input bit sp, input bit dv, input bit d);
    int pm;
    pm = cp % (1 << SEQ_W);
    cfg_valid = cv; cfg_idx = ci[IDX_W-1:0]; cfg_pat = pm[SEQ_W-1:0]; cfg_en = ce;
    start = st; stop = sp; din_valid = dv; din = d;
    @(posedge clk);
    model_step(cv, ci, pm, ce, st, sp, dv, d);
    #1;
    check_all();
    if (bus_a.hit_valid === 1'b1) n_hits++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int idx, input int pat, input bit en);
    cyc(1, idx, pat, en, 0, 0, 0, 0);
  endtask

  task automatic go();
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  // Stop any run, then disable every slot.
  task automatic clear_slots();
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < NUM_PAT; i++) wr(i, 0, 0);
  endtask

  // Sends the n low bits of val, oldest first, with gap idle cycles after each.
  task automatic send(input int val, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      cyc(0, 0, 0, 0, 0, 0, 1, bit'((val >> i) & 1));
      idle(gap);
    end
  endtask

  initial begin
    resetn = 1'b0;
    cfg_valid = 0; cfg_idx = '0; cfg_pat = '0; cfg_en = 0;
    start = 0; stop = 0; din_valid = 0; din = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) resetn = 1'b1;

    // Reset mid-run with bits streaming
    clear_slots();
    wr(0, 5'b00000, 1);
    go();
    send(5'b01100, 3, 0);
    #2 resetn = 1'b0;
    #1;
    chk("rst_hit_valid", 32'(bus_a.hit_valid), 0);
    chk("rst_hit_mask",  32'(bus_a.hit_mask),  0);
    chk("rst_hit_idx",   32'(bus_a.hit_idx),   0);
    chk("rst_hit_cnt",   32'(bus_a.hit_cnt),   0);
    chk("rst_busy",      32'(bus_a.busy),      0);
    chk("rst_cfg_ready", 32'(bus_a.cfg_ready), 1);
    model_reset();
    @(posedge clk);
    #1 check_all();
    @(negedge clk) resetn = 1'b1;

    // All-zero pattern must not match the cleared window before fill completes
    wr(0, 5'b00000, 1);
    go();
    n_hits = 0;
    send(0, 4, 0);
    chk("zero_early", 32'(n_hits), 0);
    send(0, 1, 0);
    chk("zero_hit", 32'(n_hits), 1);
    idle(1);

    // Basic hit
    clear_slots();
    wr(1, 5'b10110, 1);
    go();
    n_hits = 0;
    send(5'b10110, 5, 0);
    chk("basic_mask", 32'(bus_a.hit_mask), 32'h2);
    chk("basic_idx",  32'(bus_a.hit_idx),  1);
    idle(1);
    chk("basic_hits", 32'(n_hits), 1);
    chk("basic_cnt",  32'(bus_a.hit_cnt), 1);

    // Priority and overlap
    clear_slots();
    wr(0, 5'b10101, 1);
    wr(2, 5'b10101, 1);
    go();
    n_hits = 0;
    send(7'b1010101, 7, 0);
    idle(1);
    chk("ovl_hits", 32'(n_hits), 2);
    chk("ovl_cnt",  32'(bus_a.hit_cnt), 2);

    // din_valid gaps inside the pattern
    clear_slots();
    wr(3, 5'b11001, 1);
    go();
    n_hits = 0;
    send(5'b11001, 5, 3);
    chk("gap_hits", 32'(n_hits), 1);

    // Stop together with the final pattern bit
    clear_slots();
    wr(1, 5'b10110, 1);
    go();
    n_hits = 0;
    send(5'b1011, 4, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 0);
    idle(2);
    chk("stop_hits", 32'(n_hits), 0);
    chk("stop_busy", 32'(bus_a.busy), 0);
    chk("stop_cnt",  32'(bus_a.hit_cnt), 0);

    // Slot write attempted during a run is refused
    go();
    cyc(1, 1, 5'b11111, 1, 0, 0, 0, 0);
    chk("run_cfg_ready", 32'(bus_a.cfg_ready), 0);
    n_hits = 0;
    send(5'b10110, 5, 0);
    idle(1);
    chk("run_cfg_hits", 32'(n_hits), 1);

    // Slot write with start in the same cycle
    clear_slots();
    cyc(1, 2, 5'b01101, 1, 1, 0, 0, 0);
    n_hits = 0;
    send(5'b01101, 5, 0);
    idle(1);
    chk("wr_start_hits", 32'(n_hits), 1);

    // Disabled slot never hits
    clear_slots();
    wr(0, 5'b01101, 0);
    go();
    n_hits = 0;
    send(5'b01101, 5, 0);
    idle(1);
    chk("dis_hits", 32'(n_hits), 0);

    // Saturation of the 2-bit counter
    clear_slots();
    wr(0, 5'b11111, 1);
    go();
    n_hits = 0;
    send(10'h3FF, 10, 0);
    idle(1);
    chk("sat_hits",  32'(n_hits), 6);
    chk("sat_cnt_a", 32'(bus_a.hit_cnt), 6);
    chk("sat_cnt_b", 32'(bus_b.hit_cnt), 3);

    // Randomized traffic against the model
    clear_slots();
    for (int k = 0; k < 2000; k++) begin
      int sel, pat;
      sel = int'($urandom_range(0, 4));
      case (sel)
        0:       pat = 5'b10110;
        1:       pat = 5'b01101;
        2:       pat = 5'b11111;
        3:       pat = 5'b00000;
        default: pat = int'($urandom_range(0, 31));
      endcase
      cyc($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)), pat,
          $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
          bit'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
